pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic, parametrised inter-stage pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) with a valid/ready
//  handshake, optional 2-entry skid buffer and synchronous flush. Each stage packs its control/data
//  fields into one DATA_W payload vector. Replaces per-stage en/flush latches: stalls become backpressure
//  (out_ready=0), and SKID=1 registers in_ready so no combinational ready path spans two stages.
// PARAMETERS
//  DATA_W     192   payload width in bits (packed instr, npc, rdat1, rdat2, control fields)
//  SKID       1     1 = 2-entry skid buffer, registered in_ready; 0 = single register, combinational ready
//  NOP_VALUE  '0    DATA_W value driven on out_data whenever out_valid=0 (bubble encoding)
// PORTS
//  CLK        in   1       clock, all state on rising edge
//  nRST       in   1       asynchronous active-low reset
//  in_valid   in   1       upstream presents a beat
//  in_ready   out  1       stage can accept a beat this cycle
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       stage holds a valid beat for downstream
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_data   out  DATA_W  payload of oldest held beat, NOP_VALUE when empty
//  flush      in   1       synchronous squash of all held and incoming beats
//  count      out  2       occupancy 0..2 (0..1 when SKID=0)
// BEHAVIOUR
//  - Storage: main register M (head) and, if SKID=1, skid register S. M/S valid bits are the state.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Data registers load only on push.
//  - out_valid = M.valid; out_data = M.valid ? M.data : NOP_VALUE. count = M.valid + S.valid.
//  - Latency: beat accepted at edge N appears on out_data after edge N, i.e. 1 cycle; order strictly FIFO.
//  - SKID=1 states: EMPTY(count0), ONE(count1), FULL(count2).
//      EMPTY: push -> ONE (in_data to M).
//      ONE: push&!pop -> FULL (in_data to S); pop&!push -> EMPTY; push&pop -> ONE (in_data to M).
//      FULL: pop -> ONE (S moves to M, S cleared); no pop -> FULL. No push possible.
//    in_ready = !S.valid, a register output (no dependence on out_ready or in_valid).
//  - SKID=0: single state bit. in_ready = !M.valid | out_ready (combinational).
//    push&pop while valid -> M reloads, stays valid; pop only -> empty.
//  - flush=1: next state EMPTY regardless of push/pop; beat pushed in the flush cycle is discarded
//    (handshake completes, upstream must not re-send). A pop in the flush cycle still completes
//    downstream. flush has priority over every other event.
//  - Reset (nRST low, asynchronous): M.valid=S.valid=0, data regs=0; immediately out_valid=0,
//    out_data=NOP_VALUE, count=0, in_ready=1. Reset mid-transfer drops all held beats; first edge after
//    nRST rises behaves as EMPTY.
//  - Overflow/underflow impossible by construction: no push when FULL, no pop when EMPTY.
//  - in_data/out_ready ignored when no transfer; X on in_data with in_valid=0 must not propagate.
// TESTING
//  1 Stream, SKID=1: out_ready=1, in_valid=1 with data 1..8 on consecutive cycles -> out_data 1..8, one
//    cycle later, out_valid held 1 for 8 cycles, count=1 throughout, in_ready never drops.
//  2 Backpressure, SKID=1: out_ready=0, push A=0xA, B=0xB -> count=2, in_ready=0 next cycle; hold C=0xC
//    on in_valid; raise out_ready -> out_data A,B,C on three consecutive cycles, C accepted exactly once.
//  3 Flush at FULL with in_valid=1 (D=0xD) -> next cycle out_valid=0, count=0, out_data=NOP_VALUE, D
//    never appears on out_data; subsequent push E emerges normally.
//  4 Async reset mid-op: count=2, drop nRST between edges -> out_valid=0, count=0, in_ready=1 before
//    next edge; after release, push 0x5 -> out_data=0x5 one cycle later.
//  5 SKID=0: M valid, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 (0x7) ->
//    in_ready=1, next cycle out_data=0x7, count=1.
//  6 SKID=1 ONE state push&pop same edge (M=0x1, in 0x2) -> count stays 1, out_data=0x2, S never valid.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready inter-stage pipeline latch with optional 2-entry skid buffer and flush.
module pipe_stage_buf #(
    parameter int                DATA_W    = 192,
    parameter bit                SKID      = 1'b1,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              flush_i,
    output logic [1:0]        count_o
);
    logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
    logic              push, pop, m_load, s_load;
    // With SKID the ready is a pure register output, breaking the cross-stage ready path
    assign in_ready_o  = SKID ? !s_valid_q : (!m_valid_q | out_ready_i);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = m_valid_q & out_ready_i;
    assign m_load      = push & (!m_valid_q | pop);
    assign s_load      = SKID & push & m_valid_q & !pop;
    assign out_valid_o = m_valid_q;
    assign out_data_o  = m_valid_q ? m_data_q : NOP_VALUE;
    assign count_o     = {1'b0, m_valid_q} + {1'b0, s_valid_q};
    always_comb begin
        m_valid_d = flush_i ? 1'b0 : (s_valid_q | push | (m_valid_q & !pop));
        s_valid_d = flush_i ? 1'b0 : (s_valid_q ? !pop : s_load);
        m_data_d  = (pop & s_valid_q) ? s_data_q : (m_load ? in_data_i : m_data_q);
        s_data_d  = s_load ? in_data_i : s_data_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_data_q  <= '0;
            s_data_q  <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_data_q  <= m_data_d;
            s_data_q  <= s_data_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: checks SKID=1 and SKID=0 instances against a bounded-queue reference model.
module tb_pipe_stage_buf;
    localparam int W = 192;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv1, or1, fl1, ir1, ov1;
    logic [W-1:0] id1, od1;
    logic [1:0]   cnt1;
    logic         iv0, or0, fl0, ir0, ov0;
    logic [W-1:0] id0, od0;
    logic [1:0]   cnt0;
    logic [W-1:0] q1[$];
    logic [W-1:0] q0[$];
    int           passes = 0;
    int           total  = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(W), .SKID(1'b1)) u_skid (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv1), .in_ready_o(ir1), .in_data_i(id1),
        .out_valid_o(ov1), .out_ready_i(or1), .out_data_o(od1), .flush_i(fl1), .count_o(cnt1)
    );

    pipe_stage_buf #(.DATA_W(W), .SKID(1'b0)) u_flat (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv0), .in_ready_o(ir0), .in_data_i(id0),
        .out_valid_o(ov0), .out_ready_i(or0), .out_data_o(od0), .flush_i(fl0), .count_o(cnt0)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare all outputs with the model, then advance one edge and apply the model's transfers
    task automatic tick();
        bit           p1, pp1, p0, pp0;
        logic [W-1:0] d1, d0;
        #1;
        chk("skid_valid", W'(ov1), W'(q1.size() != 0));
        chk("skid_data", od1, q1.size() != 0 ? q1[0] : '0);
        chk("skid_count", W'(cnt1), W'(q1.size()));
        chk("skid_ready", W'(ir1), W'(q1.size() < 2));
        chk("flat_valid", W'(ov0), W'(q0.size() != 0));
        chk("flat_data", od0, q0.size() != 0 ? q0[0] : '0);
        chk("flat_count", W'(cnt0), W'(q0.size()));
        chk("flat_ready", W'(ir0), W'(q0.size() == 0 || or0));
        p1  = iv1 && q1.size() < 2;
        pp1 = q1.size() != 0 && or1;
        p0  = iv0 && (q0.size() == 0 || or0);
        pp0 = q0.size() != 0 && or0;
        d1  = id1;
        d0  = id0;
        @(posedge clk);
        if (fl1) q1.delete();
        else begin
            if (pp1) void'(q1.pop_front());
            if (p1) q1.push_back(d1);
        end
        if (fl0) q0.delete();
        else begin
            if (pp0) void'(q0.pop_front());
            if (p0) q0.push_back(d0);
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {iv1, or1, fl1, iv0, or0, fl0} = '0;
        id1 = '0;
        id0 = '0;
        #1;
        chk("rst_valid", W'(ov1), '0);
        chk("rst_count", W'(cnt1), '0);
        chk("rst_ready", W'(ir1), W'(1));
        chk("rst_data", od1, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // Stream 1..8 at full rate
        or1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            iv1 = 1'b1;
            id1 = W'(i);
            tick();
        end
        iv1 = 1'b0;
        tick();
        tick();
        // Backpressure fills skid, C held until accepted
        or1 = 1'b0; iv1 = 1'b1; id1 = W'('hA);
        tick();
        id1 = W'('hB);
        tick();
        id1 = W'('hC);
        tick();
        or1 = 1'b1;
        tick();
        tick();
        iv1 = 1'b0;
        tick();
        tick();
        // Flush at FULL discards held beats and D
        or1 = 1'b0; iv1 = 1'b1; id1 = W'('h11);
        tick();
        id1 = W'('h12);
        tick();
        id1 = W'('hD); fl1 = 1'b1;
        tick();
        fl1 = 1'b0; iv1 = 1'b0;
        tick();
        chk("flush_count", W'(cnt1), '0);
        or1 = 1'b1; iv1 = 1'b1; id1 = W'('hE);
        tick();
        iv1 = 1'b0;
        tick();
        // ONE state push and pop on the same edge
        or1 = 1'b0; iv1 = 1'b1; id1 = W'('h1);
        tick();
        or1 = 1'b1; id1 = W'('h2);
        tick();
        or1 = 1'b0; iv1 = 1'b0;
        tick();
        chk("onepp_data", od1, W'('h2));
        chk("onepp_count", W'(cnt1), W'(1));
        or1 = 1'b1;
        tick();
        // SKID=0 combinational ready
        or0 = 1'b0; iv0 = 1'b1; id0 = W'('h3);
        tick();
        id0 = W'('h7);
        tick();
        chk("flat_stall_ready", W'(ir0), '0);
        or0 = 1'b1;
        tick();
        iv0 = 1'b0; or0 = 1'b0;
        tick();
        chk("flat_pp_data", od0, W'('h7));
        or0 = 1'b1;
        tick();
        // Asynchronous reset between edges while FULL
        or1 = 1'b0; iv1 = 1'b1; id1 = W'('h21);
        tick();
        id1 = W'('h22);
        tick();
        iv1 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", W'(ov1), '0);
        chk("arst_count", W'(cnt1), '0);
        chk("arst_ready", W'(ir1), W'(1));
        chk("arst_data", od1, '0);
        q1.delete();
        q0.delete();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        iv1 = 1'b1; id1 = W'('h5); or1 = 1'b1;
        tick();
        iv1 = 1'b0;
        tick();
        // Randomized traffic on both instances; payload is X whenever not valid
        for (int i = 0; i < 400; i++) begin
            iv1 = 1'($urandom_range(0, 2) != 0);
            or1 = 1'($urandom_range(0, 2) != 0);
            fl1 = 1'($urandom_range(0, 19) == 0);
            id1 = iv1 ? {6{$urandom}} : 'x;
            iv0 = 1'($urandom_range(0, 2) != 0);
            or0 = 1'($urandom_range(0, 2) != 0);
            fl0 = 1'($urandom_range(0, 19) == 0);
            id0 = iv0 ? {6{$urandom}} : 'x;
            tick();
        end
        {iv1, fl1, iv0, fl0} = '0;
        tick();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
